mux_arbiter: RTL and testbench

Round-robin arbiter and sequencer for the 4:1 64-bit registered mux. Four requesters present data on the mux inputs under a valid/ready handshake. The block drives the mux `ctrl` select, tracks the mux's one-cycle register latency, and presents a single valid/ready stream at the mux output. Grants are held for bursts of up to `MAX_BURST` beats, then rotate fairly.

---
 rtl/mux_arbiter.sv | 153 +++++++++++++++
 tb/tb_mux_arbiter.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_arbiter.sv
// mux_arbiter: round-robin arbiter and sequencer for a 4:1 registered mux.
// Drives the mux select, accounts for the mux register's one-cycle latency,
// and exposes the mux output as a single valid/ready stream. A grant holds
// for up to MAX_BURST beats and then rotates.
module mux_arbiter #(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req_valid,
  input  logic [3:0] req_last,
  output logic [3:0] req_ready,
  output logic [1:0] mux_ctrl,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [1:0] out_owner,
  output logic       busy
);

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned IDX_W   = 2;
  localparam int unsigned CNT_W   = 4;
  localparam logic [CNT_W-1:0] BURST_CAP = CNT_W'(MAX_BURST);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SELECT  = 2'd1,
    ST_PRESENT = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [IDX_W-1:0]   r_mux_ctrl;
  logic [IDX_W-1:0]   w_mux_ctrl_nxt;
  logic [IDX_W-1:0]   r_ptr;
  logic [IDX_W-1:0]   w_ptr_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               r_out_valid;
  logic               w_out_valid_nxt;
  logic               r_busy;
  logic               w_busy_nxt;

  logic [IDX_W-1:0]   w_winner;
  logic [IDX_W-1:0]   w_cand;
  logic               w_any_req;
  logic               w_sel_valid;
  logic               w_sel_last;
  logic               w_accept;
  logic               w_burst_end;
  logic [CNT_W-1:0]   w_cnt_inc;
  logic [IDX_W-1:0]   w_ptr_after;

  // Rotating priority search: first valid requester at or above r_ptr, mod 4.
  always_comb begin
    w_winner  = r_ptr;
    w_cand    = r_ptr;
    w_any_req = |req_valid;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_cand = IDX_W'(r_ptr + IDX_W'(k));
      if (req_valid[w_cand]) begin
        w_winner = w_cand;
      end
    end
  end

  // Per-owner request view and burst bookkeeping terms.
  always_comb begin
    w_sel_valid = req_valid[r_mux_ctrl];
    w_sel_last  = req_last[r_mux_ctrl];
    w_accept    = r_out_valid & out_ready;
    w_cnt_inc   = r_cnt + CNT_W'(1);
    w_burst_end = w_sel_last | (w_cnt_inc == BURST_CAP);
    w_ptr_after = r_mux_ctrl + IDX_W'(1);
  end

  // Next-state and next-register values; everything holds unless a state acts.
  always_comb begin
    w_state_nxt     = r_state;
    w_mux_ctrl_nxt  = r_mux_ctrl;
    w_ptr_nxt       = r_ptr;
    w_cnt_nxt       = r_cnt;
    w_out_valid_nxt = 1'b0;
    w_busy_nxt      = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_any_req) begin
          w_mux_ctrl_nxt = w_winner;
          w_cnt_nxt      = '0;
          w_state_nxt    = ST_SELECT;
        end
      end

      ST_SELECT: begin
        // The mux captures in[mux_ctrl] at the end of this cycle.
        if (w_sel_valid) begin
          w_state_nxt = ST_PRESENT;
        end else begin
          w_ptr_nxt   = w_ptr_after;
          w_state_nxt = ST_IDLE;
        end
      end

      ST_PRESENT: begin
        if (w_accept) begin
          w_cnt_nxt = w_cnt_inc;
          if (w_burst_end) begin
            w_ptr_nxt   = w_ptr_after;
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_SELECT;
          end
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    w_out_valid_nxt = (w_state_nxt == ST_PRESENT);
    w_busy_nxt      = (w_state_nxt != ST_IDLE);
  end

  // State and datapath-control registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_mux_ctrl  <= '0;
      r_ptr       <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_mux_ctrl  <= w_mux_ctrl_nxt;
      r_ptr       <= w_ptr_nxt;
      r_cnt       <= w_cnt_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

  // The accept pulse is a pass-through of out_ready to the current owner only.
  assign req_ready = w_accept ? (NUM_REQ'(1) << r_mux_ctrl) : '0;

  assign mux_ctrl  = r_mux_ctrl;
  assign out_owner = r_mux_ctrl;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;

endmodule

// File: tb/tb_mux_arbiter.sv
// tb_mux_arbiter: directed test of mux_arbiter with a model of the registered
// mux and four requesters that pop their beat queue on each req_ready pulse.
module tb_mux_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req_valid;
  logic [3:0] req_last;
  logic [3:0] req_ready;
  logic [1:0] mux_ctrl;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] out_owner;
  logic       busy;

  mux_arbiter #(.MAX_BURST(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_last  (req_last),
    .req_ready (req_ready),
    .mux_ctrl  (mux_ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_owner (out_owner),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered 4:1 mux without reset; ctrl=i selects input i+1.
  logic [63:0] mux_in [1:4];
  logic [63:0] mux_out;
  always_ff @(posedge clk) mux_out <= mux_in[3'(mux_ctrl) + 3'd1];

  logic [63:0] beat_data [4][8];
  logic        beat_last [4][8];
  int unsigned n_beats [4];
  int unsigned rd_ptr  [4];
  logic        pop     [4];
  int          exp_own [$];
  logic        out_rdy;

  int n_vec;
  int n_err;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // mode 0: no last flags, 1: every beat last, 2: only the final beat last
  task automatic load(input int r, input int n, input logic [7:0] tag, input int mode);
    for (int k = 0; k < n; k++) begin
      beat_data[r][k] = {tag, 24'(r), 32'hBEEF_0000 | 32'(k)};
      beat_last[r][k] = (mode == 1) || (mode == 2 && k == n - 1);
    end
    n_beats[r] = n;
    rd_ptr[r]  = 0;
    pop[r]     = 1'b0;
  endtask

  function automatic logic drained();
    logic d = 1'b1;
    for (int i = 0; i < 4; i++)
      if (rd_ptr[i] + (pop[i] ? 1 : 0) < n_beats[i]) d = 1'b0;
    return d;
  endfunction

  // One clock: drive at negedge, sample 1ns later, checking any handshake.
  task automatic step();
    int own;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      if (pop[i]) rd_ptr[i]++;
      pop[i] = 1'b0;
      if (rd_ptr[i] < n_beats[i]) begin
        req_valid[i]  = 1'b1;
        req_last[i]   = beat_last[i][rd_ptr[i]];
        mux_in[i + 1] = beat_data[i][rd_ptr[i]];
      end else begin
        req_valid[i]  = 1'b0;
        req_last[i]   = 1'b0;
        mux_in[i + 1] = 64'hDEAD_0000_0000_0000 | 64'(i);
      end
    end
    out_ready = out_rdy;
    #1;
    if (req_ready != 4'd0)
      check_val("ready_without_valid", 64'(req_ready & ~req_valid), 64'd0);
    if (!out_valid) begin
      check_val("ready_quiet", 64'(req_ready), 64'd0);
    end else if (out_ready) begin
      if (exp_own.size() == 0) begin
        check_val("extra_accept", 64'(out_owner), 64'hFF);
      end else begin
        own = exp_own.pop_front();
        check_val("owner", 64'(out_owner), 64'(own));
        check_val("ready_onehot", 64'(req_ready), 64'(4'b0001 << own));
        check_val("beat_data", mux_out, beat_data[own][rd_ptr[own]]);
      end
    end
    for (int i = 0; i < 4; i++)
      if (req_ready[i]) pop[i] = 1'b1;
  endtask

  task automatic drain(input string tag, input int budget);
    int   n    = 0;
    logic done = 1'b0;
    while (!done && n < budget) begin
      step();
      n++;
      done = !busy && drained();
    end
    check_val(tag, 64'(done), 64'd1);
    check_val("exp_left", 64'(exp_own.size()), 64'd0);
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < 4; i++) begin
      n_beats[i] = 0;
      rd_ptr[i]  = 0;
      pop[i]     = 1'b0;
    end
    req_valid = '0;
    req_last  = '0;
    exp_own.delete();
  endtask

  task automatic check_reset_vals(input string tag);
    check_val({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    check_val({tag, "_busy"},      64'(busy),      64'd0);
    check_val({tag, "_mux_ctrl"},  64'(mux_ctrl),  64'd0);
    check_val({tag, "_out_owner"}, 64'(out_owner), 64'd0);
    check_val({tag, "_req_ready"}, 64'(req_ready), 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clear_reqs();
    #1;
    check_reset_vals("rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    out_rdy   = 1'b1;
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) mux_in[i] = '0;
    clear_reqs();

    // Single beat from requester 2, exact cycle timing.
    do_reset();
    load(2, 1, 8'h01, 1);
    exp_own.push_back(2);
    step();
    check_val("t0_busy", 64'(busy), 64'd0);
    check_val("t0_out_valid", 64'(out_valid), 64'd0);
    step();
    check_val("t1_mux_ctrl", 64'(mux_ctrl), 64'd2);
    check_val("t1_busy", 64'(busy), 64'd1);
    check_val("t1_out_valid", 64'(out_valid), 64'd0);
    step();
    check_val("t2_out_valid", 64'(out_valid), 64'd1);
    check_val("t2_req_ready", 64'(req_ready), 64'(4'b0100));
    step();
    check_val("t3_busy", 64'(busy), 64'd0);
    check_val("t3_out_valid", 64'(out_valid), 64'd0);
    // ptr is now 3, so requester 3 beats requester 0.
    load(0, 1, 8'h02, 1);
    load(3, 1, 8'h02, 1);
    exp_own.push_back(3);
    exp_own.push_back(0);
    drain("single_drain", 40);

    // Rotation with all requesters valid.
    do_reset();
    load(0, 2, 8'h10, 1);
    load(1, 1, 8'h10, 1);
    load(2, 1, 8'h10, 1);
    load(3, 1, 8'h10, 1);
    foreach (exp_own[i]) exp_own.delete(i);
    exp_own.push_back(0); exp_own.push_back(1); exp_own.push_back(2);
    exp_own.push_back(3); exp_own.push_back(0);
    drain("rotate_drain", 80);

    // Burst cap: requester 0 streams 6 non-last beats, requester 1 waits.
    do_reset();
    load(0, 6, 8'h20, 0);
    load(1, 1, 8'h20, 1);
    for (int k = 0; k < 4; k++) exp_own.push_back(0);
    exp_own.push_back(1);
    exp_own.push_back(0);
    exp_own.push_back(0);
    drain("burst_drain", 100);

    // Backpressure: ptr=1 now; requester 1 held in PRESENT with out_ready low.
    out_rdy = 1'b0;
    load(1, 2, 8'h30, 2);
    exp_own.push_back(1);
    exp_own.push_back(1);
    repeat (3) step();
    check_val("bp_enter_valid", 64'(out_valid), 64'd1);
    for (int c = 0; c < 5; c++) begin
      step();
      check_val("bp_out_valid", 64'(out_valid), 64'd1);
      check_val("bp_out_stable", mux_out, beat_data[1][0]);
      check_val("bp_mux_ctrl", 64'(mux_ctrl), 64'd1);
      check_val("bp_no_ready", 64'(req_ready), 64'd0);
    end
    out_rdy = 1'b1;
    step();
    check_val("bp_pulse", 64'(req_ready), 64'(4'b0010));
    step();
    check_val("bp_pulse_once", 64'(req_ready), 64'd0);
    drain("bp_drain", 40);

    // Idle release: ptr=2; requester 3 offers one non-last beat then goes idle.
    load(3, 1, 8'h40, 0);
    exp_own.push_back(3);
    repeat (3) step();
    step();
    check_val("rel_select_busy", 64'(busy), 64'd1);
    check_val("rel_select_valid", 64'(out_valid), 64'd0);
    step();
    check_val("rel_idle_busy", 64'(busy), 64'd0);
    check_val("rel_idle_valid", 64'(out_valid), 64'd0);
    step();
    check_val("rel_quiet_valid", 64'(out_valid), 64'd0);
    // ptr must be 0 after the release: requester 0 wins over 2.
    load(0, 1, 8'h41, 1);
    load(2, 1, 8'h41, 1);
    exp_own.push_back(0);
    exp_own.push_back(2);
    drain("rel_drain", 40);

    // Reset mid-burst: ptr=3; requester 2 granted, abort on its second beat.
    load(2, 3, 8'h50, 0);
    exp_own.push_back(2);
    repeat (3) step();
    step();
    out_rdy = 1'b0;
    step();
    check_val("mid_present", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check_reset_vals("mid_rst");
    out_ready = 1'b1;
    #1;
    check_val("mid_rst_no_pulse", 64'(req_ready), 64'd0);
    out_rdy = 1'b1;
    repeat (2) step();
    @(negedge clk);
    rst_n = 1'b1;
    // ptr back to 0: lowest valid (2) must win over 3.
    load(3, 1, 8'h51, 1);
    exp_own.push_back(2);
    exp_own.push_back(2);
    exp_own.push_back(3);
    drain("mid_drain", 60);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
